// File: rtl/sram_march_tester_pkg.sv
// Shared types, state encoding and the test-pattern generator for the SRAM march tester.
package sram_march_tester_pkg;

  localparam int ADDR_W = 21;

  typedef logic [15:0]       num;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    PAT_CONST = 2'd0,
    PAT_ADDR  = 2'd1,
    PAT_WALK1 = 2'd2,
    PAT_NADDR = 2'd3
  } pat_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_RD     = 3'd3,
    ST_RD_GAP = 3'd4,
    ST_DONE   = 3'd5
  } tester_state_t;

  // Data word for a given address. It depends only on the mode and the address,
  // so the read pass can regenerate what the write pass stored.
  function automatic num pat_word(pat_mode_t mode, addr_t addr, num const_pat);
    num w;
    case (mode)
      PAT_CONST: w = const_pat;
      PAT_ADDR:  w = addr[15:0];
      PAT_WALK1: w = num'(16'h0001) << addr[3:0];
      PAT_NADDR: w = ~addr[15:0];
      default:   w = const_pat;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sram_march_tester_if.sv
// Request/response bus between the march tester and the SRAM controller.
//
// Handshake: write_data / read_data are request levels. The master raises one of
// them together with data_addr (and data_in for writes) and holds all of them
// stable until the slave pulses sram_ready for exactly one cycle. That cycle
// completes the access; for reads data_out is valid only in that cycle. The
// master drops the request in the following cycle and never raises both
// requests at the same time.
interface sram_march_tester_if;
  import sram_march_tester_pkg::*;

  num    data_in;
  num    data_out;
  addr_t data_addr;
  logic  write_data;
  logic  read_data;
  logic  sram_ready;

  modport master (
    output data_in,
    output data_addr,
    output write_data,
    output read_data,
    input  data_out,
    input  sram_ready
  );

  modport slave (
    input  data_in,
    input  data_addr,
    input  write_data,
    input  read_data,
    output data_out,
    output sram_ready
  );

endinterface

// File: rtl/sram_march_tester.sv
// Restartable SRAM self-test: writes a pattern over an address range, reads it
// back and reports mismatch count, first failing address and pass/fail.
module sram_march_tester
  import sram_march_tester_pkg::*;
#(
  parameter addr_t ADDR_FIRST = 21'h000000,
  parameter addr_t ADDR_LAST  = 21'h0000FF,
  parameter num    CONST_PAT  = 16'h8AF5,
  parameter int    ERR_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output tester_state_t        state_dbg,
  sram_march_tester_if.master  bus
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  tester_state_t    state_q, state_d;
  addr_t            addr_q, addr_d;
  pat_mode_t        mode_q, mode_d;
  logic [ERR_W-1:0] err_q, err_d;
  addr_t            first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  num               pat_cur;

  assign pat_cur = pat_word(mode_q, addr_q, CONST_PAT);

  // State and datapath registers; reset drops any in-flight request at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mode_q  <= PAT_CONST;
      err_q   <= '0;
      first_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: sequencing of write pass, read pass and result bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    err_d   = err_q;
    first_d = first_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d  = pat_mode_t'(mode);
          err_d   = '0;
          first_d = '0;
          done_d  = 1'b0;
          addr_d  = ADDR_FIRST;
          busy_d  = 1'b1;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (bus.sram_ready) state_d = ST_WR_GAP;
      end
      ST_WR_GAP: begin
        if (addr_q == ADDR_LAST) begin
          addr_d  = ADDR_FIRST;
          state_d = ST_RD;
        end else begin
          addr_d  = addr_q + 21'd1;
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        if (bus.sram_ready) begin
          if (bus.data_out != pat_cur) begin
            if (err_q == '0) first_d = addr_q;
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          end
          state_d = ST_RD_GAP;
        end
      end
      ST_RD_GAP: begin
        if (addr_q == ADDR_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 21'd1;
          state_d = ST_RD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request and bus outputs decode directly from the registered state.
  always_comb begin
    bus.write_data = (state_q == ST_WR);
    bus.read_data  = (state_q == ST_RD);
    bus.data_addr  = ((state_q == ST_WR) || (state_q == ST_RD)) ? addr_q : '0;
    bus.data_in    = (state_q == ST_WR) ? pat_cur : '0;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_sram_march_tester.sv
// Bench for sram_march_tester: behavioural SRAM controller (latency 3), an
// expected-access queue checked every cycle, and directed test runs.
module tb_sram_march_tester;
  import sram_march_tester_pkg::*;

  localparam int    L       = 3;
  localparam int    ERR_W   = 4;
  localparam int    ERR_SAT = (1 << ERR_W) - 1;
  localparam int    N_WORDS = 16;
  localparam addr_t A_FIRST = 21'd0;
  localparam addr_t A_LAST  = 21'd15;
  localparam num    CPAT    = 16'h8AF5;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [1:0]           mode = 2'd0;
  logic                 busy, done, pass;
  logic [ERR_W-1:0]     err_count;
  logic [ADDR_W-1:0]    first_err_addr;
  tester_state_t        st_dbg;

  always #10 clk = ~clk;

  sram_march_tester_if bus();

  sram_march_tester #(
    .ADDR_FIRST (A_FIRST),
    .ADDR_LAST  (A_LAST),
    .CONST_PAT  (CPAT),
    .ERR_W      (ERR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .mode           (mode),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .state_dbg      (st_dbg),
    .bus            (bus)
  );

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural SRAM controller ----------------
  num    mem [N_WORDS];
  logic  stuck_en   = 1'b0;
  int    stuck_addr = 0;
  num    stuck_mask = 16'h0000;
  logic  force_zero = 1'b0;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        bus.sram_ready <= 1'b0;
        bus.data_out   <= 16'h0000;
        cnt = 0;
      end else if (bus.sram_ready) begin
        bus.sram_ready <= 1'b0;
        cnt = 0;
      end else if (bus.write_data || bus.read_data) begin
        if (cnt == L - 1) begin
          cnt = 0;
          bus.sram_ready <= 1'b1;
          if (bus.write_data) begin
            mem[bus.data_addr[3:0]] = bus.data_in;
          end else if (force_zero) begin
            bus.data_out <= 16'h0000;
          end else if (stuck_en && (int'(bus.data_addr) == stuck_addr)) begin
            bus.data_out <= mem[bus.data_addr[3:0]] | stuck_mask;
          end else begin
            bus.data_out <= mem[bus.data_addr[3:0]];
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {is_write, address, write data (0 for reads)}
  logic [37:0] exp_q[$];
  num          wr_seen [N_WORDS];

  function automatic num model_pat(input int m, input int a);
    case (m)
      0:       return CPAT;
      1:       return num'(a % 65536);
      2:       return num'(1 << (a % 16));
      default: return num'(65535 - (a % 65536));
    endcase
  endfunction

  // Compare process: every cycle with an active request is checked.
  initial begin
    logic        prev_req;
    logic        prev_ready;
    logic        req;
    logic [37:0] cur;
    logic [37:0] act;
    logic [37:0] e;
    prev_req   = 1'b0;
    prev_ready = 1'b0;
    cur        = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req   = 1'b0;
        prev_ready = 1'b0;
      end else begin
        req = bus.write_data || bus.read_data;
        act = {bus.write_data, bus.data_addr, bus.write_data ? bus.data_in : 16'h0000};
        if (bus.write_data && bus.read_data)
          chk("both_requests", 64'(1), 64'(0));
        if (req && prev_ready)
          chk("req_after_ready", 64'(1), 64'(0));
        if (req && !prev_req) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_access", 64'(act), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("access", 64'(act), 64'(e));
          end
          cur = act;
          if (bus.write_data) wr_seen[bus.data_addr[3:0]] = bus.data_in;
        end else if (req) begin
          if (act !== cur) chk("req_stable", 64'(act), 64'(cur));
        end
        prev_req   = req;
        prev_ready = bus.sram_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_test(input int m, input bit mid_pulse, input string tag);
    int exp_err;
    int exp_first;
    int cyc;
    num wv;
    num rv;
    exp_err   = 0;
    exp_first = 0;
    cyc       = 0;
    for (int a = 0; a < N_WORDS; a++)
      exp_q.push_back({1'b1, 21'(a), model_pat(m, a)});
    for (int a = 0; a < N_WORDS; a++) begin
      exp_q.push_back({1'b0, 21'(a), 16'h0000});
      wv = model_pat(m, a);
      if (force_zero)                          rv = 16'h0000;
      else if (stuck_en && (a == stuck_addr))  rv = wv | stuck_mask;
      else                                     rv = wv;
      if (rv != wv) begin
        if (exp_err == 0) exp_first = a;
        if (exp_err < ERR_SAT) exp_err++;
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_at_start"}, 64'(busy), 64'(1));
    chk({tag, "_err_cleared"}, 64'(err_count), 64'(0));
    chk({tag, "_done_cleared"}, 64'(done), 64'(0));
    while (!done && cyc < 1000) begin
      if (mid_pulse && cyc == 50) begin
        start = 1'b1;
        mode  = 2'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    start = 1'b0;
    chk({tag, "_run_cycles"}, 64'(cyc), 64'(2 * N_WORDS * (L + 2)));
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_pass"}, 64'(pass), 64'(exp_err == 0));
    chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
    chk({tag, "_first_err"}, 64'(first_err_addr), 64'(exp_first));
    chk({tag, "_accesses_left"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  // ---------------- timeout ----------------
  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_err", 64'(err_count), 64'(0));
    chk("rst_first", 64'(first_err_addr), 64'(0));
    chk("rst_wr", 64'(bus.write_data), 64'(0));
    chk("rst_rd", 64'(bus.read_data), 64'(0));
    chk("rst_addr", 64'(bus.data_addr), 64'(0));
    chk("rst_din", 64'(bus.data_in), 64'(0));
    chk("rst_state", 64'(st_dbg), 64'(ST_IDLE));
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Clean address-pattern run, with a start pulse while busy.
    run_test(1, 1'b1, "t1");
    chk("t1_lit_pass", 64'(pass), 64'(1));
    chk("t1_lit_wr5", 64'(wr_seen[5]), 64'(16'h0005));

    // Stuck bit 3 on word 5.
    stuck_en   = 1'b1;
    stuck_addr = 5;
    stuck_mask = 16'h0008;
    run_test(1, 1'b0, "t2");
    chk("t2_lit_err", 64'(err_count), 64'(1));
    chk("t2_lit_first", 64'(first_err_addr), 64'(5));
    chk("t2_lit_pass", 64'(pass), 64'(0));
    stuck_en = 1'b0;

    // Walking one, then constant pattern.
    run_test(2, 1'b0, "t3w");
    chk("t3_lit_wr4", 64'(wr_seen[4]), 64'(16'h0010));
    chk("t3_lit_wr15", 64'(wr_seen[15]), 64'(16'h8000));
    run_test(0, 1'b0, "t3c");
    chk("t3_lit_wr9", 64'(wr_seen[9]), 64'(16'h8AF5));
    chk("t3_lit_pass", 64'(pass), 64'(1));

    // Reset during the write of address 7.
    for (int a = 0; a < N_WORDS; a++)
      exp_q.push_back({1'b1, 21'(a), model_pat(1, a)});
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(bus.write_data && bus.data_addr == 21'd7) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("t4_reached_addr7", 64'(w < 500), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t4_wr_dropped", 64'(bus.write_data), 64'(0));
    chk("t4_rd_low", 64'(bus.read_data), 64'(0));
    chk("t4_busy_low", 64'(busy), 64'(0));
    chk("t4_done_low", 64'(done), 64'(0));
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk("t4_quiet", 64'({busy, bus.write_data, bus.read_data}), 64'(0));
    end

    // Saturating error count: readback always zero, inverted-address pattern.
    force_zero = 1'b1;
    run_test(3, 1'b0, "t5");
    chk("t5_lit_err", 64'(err_count), 64'(15));
    chk("t5_lit_first", 64'(first_err_addr), 64'(0));
    force_zero = 1'b0;

    // Restart after a failing run with a healthy memory.
    run_test(3, 1'b0, "t6");
    chk("t6_lit_err", 64'(err_count), 64'(0));
    chk("t6_lit_pass", 64'(pass), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_march_tester.md
Name: sram_march_tester

Overview:
- Upstream request generator for the `sram` controller.
- On `start`:
  - writes a selectable data pattern over a configurable address range;
  - reads the range back;
  - compares each read word and reports error count, first failing address and pass/fail.
- Replaces hand-written one-shot write/read sequencing in board-level tops with a reusable, restartable memory self-test.

Parameters:
- ADDR_FIRST, 21'h000000, first word address tested
- ADDR_LAST, 21'h0000FF, last word address tested, inclusive; must be >= ADDR_FIRST
- CONST_PAT, 16'h8AF5, word written in constant-pattern mode
- ERR_W, 16, width of saturating error counter

Ports:
- clk  in  1  system clock (50 MHz board clock)
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a test when idle or done
- mode  in  2  pattern select, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  high after read pass completes; held until next accepted start or reset
- pass  out  1  done && err_count==0
- err_count  out  ERR_W  mismatches in last run, saturating
- first_err_addr  out  21  address of first mismatch; 0 if none
- data_in  out  16 (num)  write data to sram controller
- data_out  in  16 (num)  read data from sram controller
- data_addr  out  21  word address to sram controller
- write_data  out  1  write request level
- read_data  out  1  read request level
- sram_ready  in  1  one-cycle completion strobe from controller; data_out valid in the same cycle for reads

Behaviour:
- Reset (synchronous): state IDLE. All outputs 0: busy, done, pass, err_count, first_err_addr, data_in, data_addr, write_data, read_data. Reset mid-operation drops both requests at that same edge; no further accesses issue.
- Patterns, pure function of mode and address a:
  - 0: CONST_PAT
  - 1: a[15:0]
  - 2: 16'h1 << a[3:0] (walking one)
  - 3: ~a[15:0]
- States: IDLE, WR, WR_GAP, RD, RD_GAP, DONE.
- IDLE/DONE, start=1:
  - latch mode;
  - clear err_count, first_err_addr, done, pass;
  - set addr=ADDR_FIRST, busy=1;
  - go WR.
- start while busy: ignored.
- WR:
  - write_data=1, read_data=0, data_addr=addr, data_in=pattern(addr), all stable while waiting.
  - On sram_ready go WR_GAP.
- WR_GAP:
  - both requests 0 for exactly one cycle.
  - If addr==ADDR_LAST: addr=ADDR_FIRST, go RD. Else addr+1, go WR.
- RD:
  - read_data=1, write_data=0, data_addr=addr.
  - On sram_ready compare data_out with pattern(addr). On mismatch:
    - if err_count==0, first_err_addr=addr;
    - err_count increments, saturating at all-ones.
  - Go RD_GAP.
- RD_GAP:
  - one cycle, requests 0.
  - If addr==ADDR_LAST go DONE, busy=0, done=1. Else addr+1, go RD.
- Requests are never asserted together, and never in the cycle after sram_ready.
- sram_ready outside WR/RD is ignored.
- ADDR_FIRST==ADDR_LAST: one write, one read.
- No address wrap: the addr increment never exceeds ADDR_LAST.
- Access timing: sram_ready latency L cycles after request rise gives L+2 cycles per access. Total run is 2·N·(L+2) cycles, N = ADDR_LAST−ADDR_FIRST+1.

Decomposition:
- Shared memory package holds:
  - num (16-bit) typedef;
  - pat_mode_t enum: PAT_CONST, PAT_ADDR, PAT_WALK1, PAT_NADDR;
  - tester state enum;
  - pattern function pat_word(mode, addr).
- No sub-module: single always_ff FSM plus combinational request/data outputs.

Test Plan:
- Bench model: behavioural SRAM controller with sram_ready latency L=3; ADDR_LAST=15.
- Test 1 (clean run): mode=1 → 16 writes with data_in==addr, then 16 reads. done=1, pass=1, err_count=0, run length 2·16·5=160 cycles.
- Test 2 (stuck bit): model forces bit 3 of word 5 high, mode=1 (addr 5 = 16'h0005 → reads 16'h000D) → err_count=1, first_err_addr=5, pass=0.
- Test 3 (walking one): mode=2 → addr 4 writes 16'h0010, addr 15 writes 16'h8000; mode=0 writes 16'h8AF5 everywhere. Both pass.
- Test 4 (start and reset during a run): start pulsed while busy → no restart, counts unchanged. Reset asserted during WR at addr 7 → write_data=0 and busy=0 after that edge, no further sram requests.
- Test 5 (saturation): ERR_W=4, model returns 16'h0000 always, mode=3 → err_count saturates at 15 (16 mismatches), first_err_addr=0.
- Test 6 (restart after done): start re-pulsed after a failing run with a fixed model → err_count cleared to 0 at start; pass=1 at the new done.
